// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit and its external ALU:
// field widths, opcode constants and the sequencer state encoding.
package control_unit_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int REG_W  = 2;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1000;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1001;
    localparam logic [OP_W-1:0] OP_BEQZ = 4'b1010;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_IMM,
        ST_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SLT};
    endfunction

    function automatic logic has_imm(input logic [OP_W-1:0] op);
        return op inside {OP_LDI, OP_JMP, OP_BEQZ};
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit teaching CPU: fetches instruction and
// immediate bytes, steers the external register file and ALU, handles jumps.
module control_unit
    import control_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [OP_W-1:0]   alu_op,
    input  logic              alu_zero,
    output logic [REG_W-1:0]  rf_raddr_a,
    output logic [REG_W-1:0]  rf_raddr_b,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic              rf_wsel,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] pc,
    output logic              zero_flag,
    output logic              halted
);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  ir;
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rd, rs;
    logic               take_branch;

    assign opcode      = ir[7:4];
    assign rd          = ir[3:2];
    assign rs          = ir[1:0];
    assign take_branch = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && zero_flag);

    assign imem_addr  = pc;
    assign rf_raddr_a = rd;
    assign rf_raddr_b = rs;
    assign rf_waddr   = rd;
    assign rf_wsel    = (opcode == OP_LDI);

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        alu_op    = OP_NOP;
        rf_we     = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_alu_op(opcode))      state_nxt = ST_EXEC;
                else if (has_imm(opcode))   state_nxt = ST_IMM;
                else if (opcode == OP_HALT) state_nxt = ST_HALT;
                else                        state_nxt = ST_FETCH;
            end
            ST_EXEC: begin
                alu_op    = opcode;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                rf_we     = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_IMM: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = (opcode == OP_LDI) ? ST_WB : ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = ST_FETCH;
        endcase
        // The state register is already FETCH during reset; keep the bus quiet.
        if (!rst_n) imem_req = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= '0;
            ir        <= '0;
            imm       <= '0;
            zero_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + 8'd1;
                    end
                end
                ST_EXEC: zero_flag <= alu_zero;
                ST_IMM: begin
                    if (imem_ack) begin
                        imm <= imem_rdata;
                        pc  <= take_branch ? imem_rdata : pc + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: an instruction-level model predicts every memory access and
// register write; a monitor compares them as the control unit produces them.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b1;
    logic [7:0] imem_rdata;
    logic [3:0] alu_op;
    logic       alu_zero;
    logic [1:0] rf_raddr_a, rf_raddr_b;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic       rf_wsel;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       zero_flag;
    logic       halted;

    typedef struct packed {
        logic [1:0] waddr;
        logic [7:0] data;
        logic       wsel;
        logic       z;
    } wr_t;

    logic [7:0] mem [256];
    logic [7:0] rf [4];
    logic [7:0] rfInit [4];
    logic [7:0] aluResult;
    logic [7:0] noise = 8'h00;
    int         ackPercent = 100;
    bit         monitorOn = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] expAddrQ[$];
    wr_t        expWrQ[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .alu_op(alu_op), .alu_zero(alu_zero),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
        .imm(imm), .pc(pc), .zero_flag(zero_flag), .halted(halted)
    );

    function automatic logic [7:0] aluf(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return ~a;
            4'd7:    return (a < b) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // External datapath: memory, ALU with a result latch, and register file.
    assign alu_zero   = (aluf(alu_op, rf[rf_raddr_a], rf[rf_raddr_b]) == 8'h00);
    assign imem_rdata = imem_req ? mem[imem_addr] : noise;

    always @(posedge clk) begin
        if (!rst_n) begin
            rf <= rfInit;
        end else begin
            if (alu_op != 4'd0) aluResult <= aluf(alu_op, rf[rf_raddr_a], rf[rf_raddr_b]);
            if (rf_we) rf[rf_waddr] <= rf_wsel ? imm : aluResult;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_ack = ($urandom_range(99) < ackPercent);
            noise    = 8'($urandom);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Instruction-set model: executes the program and records the expected bus traffic.
    task automatic runModel(input int maxInstr, output bit halts, output logic [7:0] endPc, output logic endZ);
        logic [7:0] r [4];
        logic [7:0] p;
        logic       z;
        logic [7:0] ins, v;
        logic [3:0] op;
        logic [1:0] rd, rs;
        wr_t        w;
        p = 8'h00;
        z = 1'b0;
        halts = 1'b0;
        for (int i = 0; i < 4; i++) r[i] = rfInit[i];
        for (int n = 0; n < maxInstr && !halts; n++) begin
            ins = mem[p];
            expAddrQ.push_back(p);
            p = p + 8'd1;
            op = ins[7:4];
            rd = ins[3:2];
            rs = ins[1:0];
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7: begin
                    v = aluf(op, r[rd], r[rs]);
                    z = (v == 8'h00);
                    r[rd] = v;
                    w.waddr = rd; w.data = v; w.wsel = 1'b0; w.z = z;
                    expWrQ.push_back(w);
                end
                4'd8: begin
                    v = mem[p];
                    expAddrQ.push_back(p);
                    p = p + 8'd1;
                    r[rd] = v;
                    w.waddr = rd; w.data = v; w.wsel = 1'b1; w.z = z;
                    expWrQ.push_back(w);
                end
                4'd9: begin
                    expAddrQ.push_back(p);
                    p = mem[p];
                end
                4'd10: begin
                    expAddrQ.push_back(p);
                    p = z ? mem[p] : p + 8'd1;
                end
                4'd15: halts = 1'b1;
                default: ;
            endcase
        end
        endPc = p;
        endZ  = z;
    endtask

    // Runs the program in mem from reset and lets the monitor check it against the model.
    task automatic applyStimulus(input string name, input int maxInstr, input int ackPct);
        bit         halts;
        logic [7:0] endPc;
        logic       endZ;
        int         budget;
        rst_n = 1'b0;
        monitorOn = 1'b0;
        ackPercent = ackPct;
        expAddrQ.delete();
        expWrQ.delete();
        runModel(maxInstr, halts, endPc, endZ);
        repeat (2) @(posedge clk);
        #1;
        monitorOn = 1'b1;
        rst_n = 1'b1;
        budget = 0;
        while ((expAddrQ.size() != 0 || expWrQ.size() != 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 2000) checkOutput({name, " pending events at timeout"}, expAddrQ.size() + expWrQ.size(), 0);
        if (halts) begin
            repeat (3) @(negedge clk);
            checkOutput({name, " halted"}, halted, 1);
            checkOutput({name, " imem_req after halt"}, imem_req, 0);
            checkOutput({name, " final pc"}, pc, endPc);
            checkOutput({name, " final zero_flag"}, zero_flag, endZ);
        end
        monitorOn = 1'b0;
        #1 rst_n = 1'b0;
    endtask

    initial begin : monitor
        logic [7:0] a;
        wr_t        w;
        forever begin
            @(negedge clk);
            if (monitorOn && rst_n) begin
                if (imem_req && imem_ack) begin
                    if (expAddrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected imem access: actual addr=%0h required none", imem_addr);
                    end else begin
                        a = expAddrQ.pop_front();
                        checkOutput("imem_addr", imem_addr, a);
                    end
                end
                if (rf_we) begin
                    if (expWrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected rf write: actual waddr=%0h required none", rf_waddr);
                    end else begin
                        w = expWrQ.pop_front();
                        checkOutput("rf_waddr", rf_waddr, w.waddr);
                        checkOutput("rf_wsel", rf_wsel, w.wsel);
                        checkOutput("rf write data", rf_wsel ? imm : aluResult, w.data);
                        checkOutput("zero_flag at write", zero_flag, w.z);
                        checkOutput("alu_op during write", alu_op, 0);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic       weSeen [6];
        logic [3:0] opSeen [6];
        logic [1:0] waSeen [6];
        logic [7:0] pcSeen [6];

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) rfInit[i] = 8'($urandom);

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("reset pc", pc, 8'h00);
        checkOutput("reset imm", imm, 8'h00);
        checkOutput("reset zero_flag", zero_flag, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset rf_we", rf_we, 0);
        checkOutput("reset alu_op", alu_op, 0);
        checkOutput("reset imem_req", imem_req, 0);

        // ADD r3,r1 with ack high: cycle-exact timing of EXEC and WB.
        mem[0] = 8'h1D;
        mem[1] = 8'hF0;
        ackPercent = 100;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            weSeen[c] = rf_we;
            opSeen[c] = alu_op;
            waSeen[c] = rf_waddr;
            pcSeen[c] = pc;
        end
        checkOutput("add rf_we cycle3", weSeen[3], 0);
        checkOutput("add alu_op cycle3", opSeen[3], 4'b0001);
        checkOutput("add rf_we cycle4", weSeen[4], 1);
        checkOutput("add rf_waddr cycle4", waSeen[4], 3);
        checkOutput("add alu_op cycle4", opSeen[4], 0);
        checkOutput("add pc cycle4", pcSeen[4], 8'h01);
        checkOutput("add rf_we cycle5", weSeen[5], 0);

        // LDI r2,0xA5 then reset during its WB cycle.
        rst_n = 1'b0;
        mem[0] = 8'h88;
        mem[1] = 8'hA5;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("ldi rf_we", rf_we, 1);
        checkOutput("ldi rf_waddr", rf_waddr, 2);
        checkOutput("ldi rf_wsel", rf_wsel, 1);
        checkOutput("ldi imm", imm, 8'hA5);
        checkOutput("ldi pc", pc, 8'h02);
        checkOutput("ldi zero_flag", zero_flag, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset in wb rf_we", rf_we, 0);
        checkOutput("reset in wb pc", pc, 8'h00);
        checkOutput("reset in wb imem_req", imem_req, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first fetch req after reset", imem_req, 1);
        checkOutput("first fetch addr after reset", imem_addr, 8'h00);

        // SUB r0,r0 sets Z; BEQZ 0x40 taken.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20; mem[1] = 8'hA0; mem[2] = 8'h40; mem[8'h40] = 8'hF0;
        applyStimulus("beqz taken", 10, 100);

        // LDI r0,5; LDI r1,3; SUB r0,r1 clears Z; BEQZ 0x40 falls through.
        mem[0] = 8'h80; mem[1] = 8'h05; mem[2] = 8'h84; mem[3] = 8'h03;
        mem[4] = 8'h21; mem[5] = 8'hA0; mem[6] = 8'h40; mem[7] = 8'hF0;
        applyStimulus("beqz not taken", 10, 100);

        // JMP 0xFF with a NOP there: pc wraps back to 0x00.
        mem[0] = 8'h90; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
        applyStimulus("jmp wrap", 7, 60);

        // Random programs with random acknowledge stalls.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) rfInit[i] = 8'($urandom);
            applyStimulus("random program", 40, (t == 0) ? 100 : 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
